cmd_sequencer: RTL
==================

CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, command queue depth (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 24'd5_000_000, max clocks to wait for cmd_sent or resp_rdy.
REQ-003 SHALL have parameter MAX_RETRY, default 2, reissues allowed per command after nack/timeout.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 Ports, clock and reset first:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- push  in  1  enqueue push_cmd this cycle
- push_cmd  in  16  tour command word (e.g. 16'h4BF1)
- full  out  1  queue holds DEPTH entries
- empty  out  1  queue holds 0 entries
- count  out  $clog2(DEPTH+1)  queue occupancy
- start  in  1  begin draining queue
- abort  in  1  stop and flush
- cmd  out  16  word to RemoteComm
- send_cmd  out  1  one-cycle issue strobe to RemoteComm
- cmd_sent  in  1  RemoteComm finished transmitting
- resp_rdy  in  1  response byte valid
- resp  in  8  response byte
- busy  out  1  sequencer not IDLE/FAULT
- done  out  1  one-cycle pulse, queue drained, all acked
- err  out  1  sticky fault flag
- err_code  out  2  00 none, 01 nack, 10 timeout
- acked_cnt  out  8  commands acknowledged since reset

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, WAIT_SENT, WAIT_ACK, FAULT.
REQ-007 IDLE + start + !empty SHALL enter ISSUE next cycle; IDLE + start + empty SHALL pulse done next cycle and stay IDLE.
REQ-008 ISSUE SHALL drive cmd = queue head, assert send_cmd exactly one cycle, clear timer, enter WAIT_SENT.
REQ-009 cmd SHALL stay stable from ISSUE until leaving WAIT_ACK.
REQ-010 WAIT_SENT + cmd_sent SHALL enter WAIT_ACK with timer cleared.
REQ-011 WAIT_ACK + resp_rdy + resp==8'hA5 SHALL pop head, increment acked_cnt (wraps 255->0), clear retry count; next state ISSUE if queue non-empty after pop, else IDLE with done pulsed one cycle.
REQ-012 WAIT_ACK + resp_rdy + resp!=8'hA5 SHALL reissue same head (ISSUE) if retries<MAX_RETRY, else enter FAULT with err_code=01; head not popped.
REQ-013 Timer reaching TIMEOUT_CYCLES in WAIT_SENT or WAIT_ACK SHALL act as REQ-012 but with err_code=10.
REQ-014 FAULT SHALL hold err=1, busy=0; start in FAULT SHALL clear err/err_code and enter ISSUE with retained head.
REQ-015 abort in any state SHALL flush queue, clear retry count, enter IDLE next cycle; err unchanged; abort wins over start/push same cycle.
REQ-016 push when !full SHALL enqueue; push when full and no pop same cycle SHALL be ignored with no corruption; push+pop same cycle SHALL leave count unchanged.
REQ-017 push SHALL be accepted in every state, including busy.
REQ-018 start while busy SHALL be ignored; resp_rdy/cmd_sent outside WAIT_SENT/WAIT_ACK SHALL be ignored.
REQ-019 cmd_sent and resp_rdy asserted same cycle in WAIT_SENT SHALL advance only to WAIT_ACK (response dropped).

Reset
REQ-020 rst SHALL set: state IDLE, queue empty, count 0, empty 1, full 0, cmd 16'h0000, send_cmd 0, busy 0, done 0, err 0, err_code 00, acked_cnt 0, timer and retry count 0.
REQ-021 rst mid-transaction SHALL take priority over all inputs; no send_cmd in the reset cycle or following cycle.

Structure
REQ-022 Package tour_seq_pkg SHALL hold state enum, err_code enum, ACK_BYTE=8'hA5.
REQ-023 Queue SHALL be sub-module cmd_fifo (sync FIFO, DEPTH/width parameters, push/pop/full/empty/count).

Verification
REQ-024 Push 16'h2000,16'h4BF1; start; ack A5 each after cmd_sent -> two send_cmd pulses, cmd order 2000 then 4BF1, done pulse, acked_cnt=2.
REQ-025 Push 16'h4002; respond 8'h5A three times (MAX_RETRY=2) -> three send_cmd pulses, FAULT, err=1, err_code=01, count=1.
REQ-026 TIMEOUT_CYCLES=100, never assert cmd_sent -> reissue at 100-clock intervals, FAULT err_code=10 after 3rd timeout; start then ack -> done, err=0.
REQ-027 Push 9 words with DEPTH=8 -> full=1, count=8, 9th dropped; drain gives exactly 8 acks in order.
REQ-028 abort in WAIT_ACK with 3 queued -> IDLE next cycle, empty=1, late resp_rdy ignored, acked_cnt unchanged.
REQ-029 rst asserted in WAIT_SENT -> all outputs at REQ-020 values next cycle.

Source files
------------

// File: rtl/tour_seq_pkg.sv
// Shared types and constants for the tour command sequencer.
package tour_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitSent,
    StWaitAck,
    StFault
  } seq_state_e;

  typedef enum logic [1:0] {
    ErrNone    = 2'b00,
    ErrNack    = 2'b01,
    ErrTimeout = 2'b10
  } err_code_e;

  localparam logic [7:0] ACK_BYTE = 8'hA5;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with flush; a push into a full queue is accepted only when a pop frees a slot.
module cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !flush_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !flush_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/cmd_sequencer.sv
// Drains queued tour commands to RemoteComm one at a time, waiting for an 0xA5 ack
// per command with bounded retries on nack or timeout.
module cmd_sequencer
  import tour_seq_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [15:0]                  push_cmd,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  input  logic                         start,
  input  logic                         abort,
  output logic [15:0]                  cmd,
  output logic                         send_cmd,
  input  logic                         cmd_sent,
  input  logic                         resp_rdy,
  input  logic [7:0]                   resp,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [1:0]                   err_code,
  output logic [7:0]                   acked_cnt
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);

  seq_state_e    state_q, state_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          send_cmd_q, send_cmd_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  err_code_e     err_code_q, err_code_d;
  logic [7:0]    acked_q, acked_d;
  logic [23:0]   timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;

  logic          pop, flush, fail, timeout;
  err_code_e     fail_code;
  logic [15:0]   head;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .push_i  (push),
    .data_i  (push_cmd),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign timeout = (timer_q == TIMEOUT_CYCLES - 24'd1);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    send_cmd_d = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    err_code_d = err_code_q;
    acked_d    = acked_q;
    timer_d    = timer_q;
    retry_d    = retry_q;
    pop        = 1'b0;
    flush      = 1'b0;
    fail       = 1'b0;
    fail_code  = ErrNone;

    if (abort) begin
      flush   = 1'b1;
      retry_d = '0;
      timer_d = '0;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (!empty) state_d = StIssue;
            else        done_d  = 1'b1;
          end
        end
        StIssue: begin
          cmd_d      = head;
          send_cmd_d = 1'b1;
          timer_d    = '0;
          state_d    = StWaitSent;
        end
        StWaitSent: begin
          // A response arriving with cmd_sent is deliberately dropped.
          if (cmd_sent) begin
            timer_d = '0;
            state_d = StWaitAck;
          end else if (timeout) begin
            fail      = 1'b1;
            fail_code = ErrTimeout;
          end else begin
            timer_d = timer_q + 24'd1;
          end
        end
        StWaitAck: begin
          if (resp_rdy) begin
            if (resp == ACK_BYTE) begin
              pop     = 1'b1;
              acked_d = acked_q + 8'd1;
              retry_d = '0;
              // Occupancy after this pop, counting a same-cycle push.
              if (count > CW'(1) || push) begin
                state_d = StIssue;
              end else begin
                state_d = StIdle;
                done_d  = 1'b1;
              end
            end else begin
              fail      = 1'b1;
              fail_code = ErrNack;
            end
          end else if (timeout) begin
            fail      = 1'b1;
            fail_code = ErrTimeout;
          end else begin
            timer_d = timer_q + 24'd1;
          end
        end
        StFault: begin
          if (start) begin
            err_d      = 1'b0;
            err_code_d = ErrNone;
            retry_d    = '0;
            state_d    = StIssue;
          end
        end
        default: state_d = StIdle;
      endcase

      if (fail) begin
        if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + RW'(1);
          state_d = StIssue;
        end else begin
          err_d      = 1'b1;
          err_code_d = fail_code;
          state_d    = StFault;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      send_cmd_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
      acked_q    <= '0;
      timer_q    <= '0;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      send_cmd_q <= send_cmd_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      acked_q    <= acked_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
    end
  end

  assign cmd       = cmd_q;
  assign send_cmd  = send_cmd_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign acked_cnt = acked_q;
  assign busy      = (state_q != StIdle) && (state_q != StFault);

endmodule
